// File: rtl/count_pkg.sv
// count_pkg
//   Shared definitions for the counter integrity monitor: tracking-FSM state
//   encoding and default geometry of the observed counter and error tally.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_SYNC_LEN  = 2;
    localparam int DEF_ERR_CNT_W = 8;

endpackage

// File: rtl/count_checker_if.sv
// count_checker_if
//   Bundles the observed-sample inputs and the monitor status outputs.
//   Sampling semantics: count_in is taken on a rising clk edge only when
//   count_valid is high; there is no back-pressure, the monitor accepts every
//   valid sample. src_reset, when high on an edge, wins over a valid sample.
//   master : sample source / observer (drives count_in, count_valid, src_reset)
//   slave  : the monitor (drives locked, expected, mismatch, wrap_pulse,
//            err_count and the dbg_state tracking-FSM view)
interface count_checker_if
    import count_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
    logic [WIDTH-1:0]     count_in;
    logic                 count_valid;
    logic                 src_reset;
    logic                 locked;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;
    logic                 wrap_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    state_t               dbg_state;

    modport master (
        output count_in, count_valid, src_reset,
        input  locked, expected, mismatch, wrap_pulse, err_count, dbg_state
    );

    modport slave (
        input  count_in, count_valid, src_reset,
        output locked, expected, mismatch, wrap_pulse, err_count, dbg_state
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   clr   : asynchronous active-high clear to zero
//   inc   : add one on this edge (ignored once at maximum)
//   count : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/count_checker.sv
// count_checker
//   Live integrity monitor for a free-running up-counter. Locks after
//   SYNC_LEN consecutive +1 steps, then predicts every next value and flags
//   any break with a mismatch pulse and a saturating error tally.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, returns every output to 0 / IDLE
//   bus   : count_checker_if.slave (samples in, status out, dbg_state)
module count_checker
    import count_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SYNC_LEN  = DEF_SYNC_LEN,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input logic            clk,
    input logic            reset,
    count_checker_if.slave bus
);
    localparam int RUN_W = $clog2(SYNC_LEN + 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [RUN_W-1:0]     run_q, run_d, run_inc;
    logic [WIDTH-1:0]     sample, sample_inc, base_inc;
    logic                 locked_q;
    logic                 mismatch_q, mismatch_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_count;

    // All increments wrap naturally at the register width.
    assign sample     = bus.count_in;
    assign sample_inc = sample + WIDTH'(1);
    assign base_inc   = base_q + WIDTH'(1);
    assign run_inc    = run_q + RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        exp_d      = exp_q;
        run_d      = run_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        if (bus.src_reset) begin
            // Source restarting: drop tracking silently, sample discarded.
            state_d = IDLE;
            run_d   = '0;
        end else if (bus.count_valid) begin
            case (state_q)
                IDLE: begin
                    base_d  = sample;
                    run_d   = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    base_d = sample;
                    if (sample == base_inc) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(SYNC_LEN)) begin
                            state_d = LOCKED;
                            exp_d   = sample_inc;
                        end
                    end else begin
                        // Not yet trusted: restart the run without penalty.
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (sample == exp_q) begin
                        exp_d  = sample_inc;
                        wrap_d = (sample == '0);
                    end else begin
                        mismatch_d = 1'b1;
                        base_d     = sample;
                        run_d      = '0;
                        state_d    = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            run_q      <= run_d;
            locked_q   <= (state_d == LOCKED);
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
        end
    end

    // Tally advances on the same edge that raises the mismatch pulse.
    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (mismatch_d),
        .count (err_count)
    );

    assign bus.locked     = locked_q;
    assign bus.expected   = exp_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.err_count  = err_count;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;
    import count_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] cin  = 4'd0;
    logic       cval = 1'b0;
    logic       srst = 1'b0;

    // Two monitors on the same stream: default tally width and a 2-bit one
    // used to exercise saturation.
    count_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
    count_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();

    assign bus_a.count_in    = cin;
    assign bus_a.count_valid = cval;
    assign bus_a.src_reset   = srst;
    assign bus_b.count_in    = cin;
    assign bus_b.count_valid = cval;
    assign bus_b.src_reset   = srst;

    count_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    count_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Compare both monitors against one set of expectations; err is the
    // unsaturated mismatch total, each tally clips it at its own maximum.
    task automatic check_all(input string tag, input logic e_locked, input logic chk_exp,
                             input logic [3:0] e_exp, input logic e_mis, input logic e_wrap,
                             input int e_err);
        int e_err_b;
        e_err_b = (e_err > 3) ? 3 : e_err;
        exp_q.push_back(8'(e_err));
        chk({tag, " locked_a"}, int'(bus_a.locked), int'(e_locked));
        chk({tag, " locked_b"}, int'(bus_b.locked), int'(e_locked));
        if (chk_exp) begin
            chk({tag, " expected_a"}, int'(bus_a.expected), int'(e_exp));
            chk({tag, " expected_b"}, int'(bus_b.expected), int'(e_exp));
        end
        chk({tag, " mismatch_a"}, int'(bus_a.mismatch), int'(e_mis));
        chk({tag, " mismatch_b"}, int'(bus_b.mismatch), int'(e_mis));
        chk({tag, " wrap_a"}, int'(bus_a.wrap_pulse), int'(e_wrap));
        chk({tag, " wrap_b"}, int'(bus_b.wrap_pulse), int'(e_wrap));
        chk({tag, " err_a"}, int'(bus_a.err_count), int'(exp_q.pop_front()));
        chk({tag, " err_b"}, int'(bus_b.err_count), e_err_b);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [3:0] d, input logic s);
        @(negedge clk);
        cval = v;
        cin  = d;
        srst = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       valid;
        logic [3:0] cin;
        logic       srst;
        logic       locked;
        logic       chk_exp;
        logic [3:0] exp_val;
        logic       mismatch;
        logic       wrap;
        int         err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0] nxt;
        int         err_tot;

        // lock on 0,1,2 with gaps in the middle of the tracked stream
        vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 4'd9,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 4'd9,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 4'd4,  1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 0});
        // break at expected=5, relock on 8,9
        vecs.push_back('{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1});
        // run up through the wrap
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd11, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd12, 1'b0, 1'b1, 1'b1, 4'd13, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd14, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1});
        // source reset with a would-be-wrong sample alongside, then relock
        vecs.push_back('{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1});
        // second break, then a non-consecutive sample while in SYNC (no error)
        vecs.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 2});
        vecs.push_back('{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, 4'd11, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 2});

        // ---- reset held 100 ns, no samples ----
        #100;
        check_all("in_reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
        chk("in_reset state_a", int'(bus_a.dbg_state), int'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 4'd0, 1'b0);
        check_all("post_reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].cin, vecs[i].srst);
            check_all($sformatf("v%0d", i), vecs[i].locked, vecs[i].chk_exp,
                      vecs[i].exp_val, vecs[i].mismatch, vecs[i].wrap, vecs[i].err);
        end

        // ---- saturation: three more breaks, relocking in between ----
        nxt     = 4'd12;
        err_tot = 2;
        for (int k = 0; k < 3; k++) begin
            err_tot++;
            step(1'b1, nxt + 4'd2, 1'b0);
            check_all($sformatf("sat%0d_break", k), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, err_tot);
            step(1'b1, nxt + 4'd3, 1'b0);
            check_all($sformatf("sat%0d_sync", k), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, err_tot);
            step(1'b1, nxt + 4'd4, 1'b0);
            nxt = nxt + 4'd5;
            check_all($sformatf("sat%0d_relock", k), 1'b1, 1'b1, nxt, 1'b0, 1'b0, err_tot);
        end

        // ---- asynchronous reset mid-operation ----
        step(1'b1, nxt, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
        chk("async_reset state_b", int'(bus_b.dbg_state), int'(IDLE));
        @(negedge clk);
        cval  = 1'b0;
        reset = 1'b0;
        step(1'b0, 4'd0, 1'b0);
        check_all("after_async_reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Pulses are mutually exclusive on every clock.
    always @(negedge clk) begin
        if (!reset && bus_a.mismatch && bus_a.wrap_pulse) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_overlap: got mismatch=1 wrap=1, want not both");
        end
    end
endmodule
